// File: rtl/text_overlay.sv
// Character-cell text overlay: buffered glyph codes are rendered over the live pixel stream.
// Latency: text_on/text_rgb follow the x,y sample by 2 clk cycles, in or out of the text region.
// Backpressure: wr_ready drops while the buffer is being swept clear and in any cycle clr is high.

// Synchronous glyph ROM, 8x16 cells, MSB is the leftmost pixel; codes without an entry render blank.
// Latency: data is registered, 1 clk after addr.
// Backpressure: none, one lookup per cycle.
module ascii_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    // Registered font lookup, address = {code[6:0], glyph line[3:0]}
    always_ff @(posedge clk) begin
        case (addr)
            {7'h41, 4'd2}:  data <= 8'h10;
            {7'h41, 4'd3}:  data <= 8'h38;
            {7'h41, 4'd4}:  data <= 8'h6C;
            {7'h41, 4'd5}:  data <= 8'hC6;
            {7'h41, 4'd6}:  data <= 8'hC6;
            {7'h41, 4'd7}:  data <= 8'hFE;
            {7'h41, 4'd8}:  data <= 8'hC6;
            {7'h41, 4'd9}:  data <= 8'hC6;
            {7'h41, 4'd10}: data <= 8'hC6;
            {7'h41, 4'd11}: data <= 8'hC6;
            {7'h48, 4'd2}:  data <= 8'hC6;
            {7'h48, 4'd3}:  data <= 8'hC6;
            {7'h48, 4'd4}:  data <= 8'hC6;
            {7'h48, 4'd5}:  data <= 8'hC6;
            {7'h48, 4'd6}:  data <= 8'hC6;
            {7'h48, 4'd7}:  data <= 8'hFE;
            {7'h48, 4'd8}:  data <= 8'hC6;
            {7'h48, 4'd9}:  data <= 8'hC6;
            {7'h48, 4'd10}: data <= 8'hC6;
            {7'h48, 4'd11}: data <= 8'hC6;
            default:        data <= 8'h00;
        endcase
    end

endmodule

module text_overlay #(
    parameter int          COLS         = 16,
    parameter int          ROWS         = 4,
    parameter int          SCALE_SHIFT  = 1,
    parameter int          X0           = 64,
    parameter int          Y0           = 32,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG           = 12'hF00,
    parameter logic [11:0] BG           = 12'h0FF,
    localparam int         NCELL        = COLS * ROWS,
    localparam int         AW           = (NCELL > 1) ? $clog2(NCELL) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          frame_tick,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    output logic          wr_ready,
    input  logic          clr,
    output logic          text_on,
    output logic [11:0]   text_rgb
);

    localparam int S  = SCALE_SHIFT;
    localparam int CW = 8 << S;
    localparam int CH = 16 << S;
    // Region bounds held at 16 bits: the far edge can lie beyond the 10-bit pixel range
    localparam logic [15:0] X_LO = 16'(X0);
    localparam logic [15:0] X_HI = 16'(X0 + COLS * CW);
    localparam logic [15:0] Y_LO = 16'(Y0);
    localparam logic [15:0] Y_HI = 16'(Y0 + ROWS * CH);
    localparam logic [AW:0]   NCELL_W = (AW + 1)'(NCELL);
    localparam logic [AW-1:0] LAST    = AW'(NCELL - 1);
    localparam int            BW      = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLAST   = BW'(BLINK_FRAMES - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t          state;
    logic [AW-1:0]   clr_addr;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [7:0]      mem_wd;
    logic [7:0]      mem [NCELL];
    logic [7:0]      rd_char;
    logic [AW-1:0]   rd_addr;
    logic [15:0]     xw, yw, dx, dy;
    logic            in_region;
    logic [2:0]      gbit;
    logic [3:0]      gline;
    logic            s1_vld;
    logic [2:0]      s1_bit;
    logic [3:0]      s1_line;
    logic            s2_vld;
    logic [2:0]      s2_bit;
    logic            s2_blink;
    logic            s2_nz;
    logic [7:0]      rom_data;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic            wr_in_range;

    // Pixel position to cell index and glyph coordinates; out-of-region reads are parked on cell 0
    always_comb begin
        xw        = {6'd0, x};
        yw        = {6'd0, y};
        dx        = xw - X_LO;
        dy        = yw - Y_LO;
        in_region = (xw >= X_LO) && (xw < X_HI) && (yw >= Y_LO) && (yw < Y_HI);
        gbit      = 3'(dx >> S);
        gline     = 4'(dy >> S);
        rd_addr   = in_region ? AW'((dy >> (4 + S)) * 16'(COLS) + (dx >> (3 + S))) : '0;
    end

    assign wr_ready    = (state == ST_IDLE) && !clr;
    assign wr_in_range = {1'b0, wr_addr} < NCELL_W;

    // Control FSM: clear sweep one cell per cycle, then accept host writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // clr is deliberately ignored here so a sweep always runs to the end
                    if (clr_addr == LAST) begin
                        state    <= ST_IDLE;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    state    <= ST_CLEAR;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Buffer write port select: sweep zeros, or an accepted in-range host write
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_addr;
        mem_wd = 8'h00;
        if (state == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            mem_we = 1'b1;
            mem_wa = wr_addr;
            mem_wd = wr_char;
        end
    end

    // Character buffer; the read samples pre-write contents on an address collision
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        rd_char <= mem[rd_addr];
    end

    // Stage 1: region flag and glyph coordinates aligned with the buffer read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_bit  <= 3'd0;
            s1_line <= 4'd0;
        end else begin
            s1_vld  <= in_region;
            s1_bit  <= gbit;
            s1_line <= gline;
        end
    end

    ascii_rom u_rom (
        .clk  (clk),
        .addr ({rd_char[6:0], s1_line}),
        .data (rom_data)
    );

    // Stage 2: flags and character attributes aligned with the ROM output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld   <= 1'b0;
            s2_bit   <= 3'd0;
            s2_blink <= 1'b0;
            s2_nz    <= 1'b0;
        end else begin
            s2_vld   <= s1_vld;
            s2_bit   <= s1_bit;
            s2_blink <= rd_char[7];
            s2_nz    <= |rd_char[6:0];
        end
    end

    // Blink timebase: phase flips every BLINK_FRAMES frame ticks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Pixel output from registered state only; code 0 is forced blank regardless of font
    always_comb begin
        text_on  = s2_vld && s2_nz && rom_data[3'd7 - s2_bit] && !(s2_blink && blink_phase);
        text_rgb = text_on ? FG : BG;
    end

endmodule

// File: tb/tb_text_overlay.sv
module tb_text_overlay;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        frame_tick;
    logic        wr_valid, wr_valid2;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_addr2;
    logic [7:0]  wr_char, wr_char2;
    logic        wr_ready, wr_ready2;
    logic        clr, clr2;
    logic        text_on, text_on2;
    logic [11:0] text_rgb, text_rgb2;

    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    logic [7:0] bufm  [64];
    logic [7:0] bufm2 [10];
    bit   blink_ph;
    int   tick_cnt;
    int   n1, n2;

    always #5 clk = ~clk;

    text_overlay dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_char(wr_char), .wr_ready(wr_ready),
        .clr(clr), .text_on(text_on), .text_rgb(text_rgb)
    );

    // Ten-cell layout: addresses 10..15 fit the 4-bit port but name no cell
    text_overlay #(.COLS(5), .ROWS(2), .SCALE_SHIFT(0), .X0(0), .Y0(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
        .wr_valid(wr_valid2), .wr_addr(wr_addr2), .wr_char(wr_char2), .wr_ready(wr_ready2),
        .clr(clr2), .text_on(text_on2), .text_rgb(text_rgb2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [6:0] c, input int ln);
        logic [7:0] g;
        g = 8'h00;
        if (c == 7'h41) begin
            case (ln)
                2: g = 8'h10;
                3: g = 8'h38;
                4: g = 8'h6C;
                5, 6, 8, 9, 10, 11: g = 8'hC6;
                7: g = 8'hFE;
                default: g = 8'h00;
            endcase
        end else if (c == 7'h48) begin
            case (ln)
                2, 3, 4, 5, 6, 8, 9, 10, 11: g = 8'hC6;
                7: g = 8'hFE;
                default: g = 8'h00;
            endcase
        end
        return g;
    endfunction

    function automatic bit model_on(input bit sel, input int px, input int py);
        int cols, rows, s, x0, y0, dx, dy, idx;
        logic [7:0] ch, g;
        cols = sel ? 5 : 16;
        rows = sel ? 2 : 4;
        s    = sel ? 0 : 1;
        x0   = sel ? 0 : 64;
        y0   = sel ? 0 : 32;
        if (px < x0 || px >= x0 + cols * (8 << s) || py < y0 || py >= y0 + rows * (16 << s))
            return 1'b0;
        dx  = px - x0;
        dy  = py - y0;
        idx = (dy >> (4 + s)) * cols + (dx >> (3 + s));
        if (sel) ch = bufm2[idx];
        else     ch = bufm[idx];
        if (ch[7] && blink_ph) return 1'b0;
        g = glyph(ch[6:0], (dy >> s) & 15);
        return g[7 - ((dx >> s) & 7)];
    endfunction

    task automatic check_px(input bit sel, input bit e, input string name);
        chk({name, " text_on"}, sel ? text_on2 : text_on, e);
        chk({name, " text_rgb"}, sel ? text_rgb2 : text_rgb, e ? 32'hF00 : 32'h0FF);
    endtask

    // New pixel every cycle; each output is compared with the pixel driven two cycles earlier
    task automatic scan(input bit sel, input int xa, input int xb, input int ya, input int yb,
                        input string tag);
        bit    eq[$];
        string tq[$];
        for (int py = ya; py <= yb; py++) begin
            for (int px = xa; px <= xb; px++) begin
                @(negedge clk);
                if (eq.size() == 2) check_px(sel, eq.pop_front(), tq.pop_front());
                x = 10'(px);
                y = 10'(py);
                eq.push_back(model_on(sel, px, py));
                tq.push_back($sformatf("%s@%0d,%0d", tag, px, py));
            end
        end
        repeat (2) begin
            @(negedge clk);
            check_px(sel, eq.pop_front(), tq.pop_front());
        end
    endtask

    task automatic do_write(input bit sel, input int a, input logic [7:0] ch, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        if (sel) begin
            wr_valid2 = 1'b1; wr_addr2 = 4'(a); wr_char2 = ch;
        end else begin
            wr_valid = 1'b1; wr_addr = 6'(a); wr_char = ch;
        end
        while (!(sel ? wr_ready2 : wr_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " handshake"}, n < 100, 1);
        @(posedge clk);
        @(negedge clk);
        wr_valid  = 1'b0;
        wr_valid2 = 1'b0;
        if (sel && a < 10) bufm2[a] = ch;
        if (!sel && a < 64) bufm[a] = ch;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            tick_cnt++;
            if (tick_cnt == 30) begin
                tick_cnt = 0;
                blink_ph = ~blink_ph;
            end
        end
    endtask

    // Cycles (sampled at negedge, first sample now) until each wr_ready is seen high
    task automatic wait_ready(input bit clr_mid, output int r1, output int r2);
        r1 = -1;
        r2 = -1;
        for (int k = 0; k < 200; k++) begin
            if (r1 < 0 && wr_ready)  r1 = k;
            if (r2 < 0 && wr_ready2) r2 = k;
            if (r1 >= 0 && r2 >= 0) break;
            clr = clr_mid && (k == 10);
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bufm[i] = 8'h00;
        for (int i = 0; i < 10; i++) bufm2[i] = 8'h00;
        blink_ph = 1'b0;
        tick_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; x = 10'd64; y = 10'd32; frame_tick = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_char = '0; clr = 1'b0;
        wr_valid2 = 1'b0; wr_addr2 = '0; wr_char2 = '0; clr2 = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst wr_ready", wr_ready, 0);
        chk("rst text_on", text_on, 0);
        chk("rst text_rgb", text_rgb, 32'h0FF);
        chk("rst wr_ready2", wr_ready2, 0);

        // Clear sweep length after reset: one cycle per cell
        reset_n = 1'b1;
        wait_ready(1'b0, n1, n2);
        chk("sweep len 64 cells", n1, 64);
        chk("sweep len 10 cells", n2, 10);

        // Blank screen around the top-left corner
        scan(1'b0, 56, 90, 30, 40, "blank");

        // 'A' in cell 0, doubled, with a margin outside the cell
        do_write(1'b0, 0, 8'h41, "wr A@0");
        scan(1'b0, 62, 81, 30, 65, "A@0");

        // Blinking 'A' in cell 17
        do_write(1'b0, 17, 8'hC1, "wr C1@17");
        scan(1'b0, 78, 97, 70, 70, "blink ph0");
        ticks(29);
        scan(1'b0, 78, 97, 70, 70, "blink 29 ticks");
        ticks(1);
        scan(1'b0, 80, 95, 64, 95, "blink hidden");
        scan(1'b0, 62, 81, 38, 38, "steady A while hidden");
        ticks(30);
        scan(1'b0, 80, 95, 64, 95, "blink shown");

        // Last cell, then one line per text row to confirm nothing else moved
        do_write(1'b0, 63, 8'h48, "wr H@63");
        scan(1'b0, 302, 321, 126, 161, "H@63");
        for (int r = 0; r < 4; r++) scan(1'b0, 60, 323, 38 + 32 * r, 38 + 32 * r, "rowline");

        // Out-of-range addresses complete their handshake and are dropped
        do_write(1'b1, 9, 8'h41, "wr2 A@9");
        do_write(1'b1, 10, 8'h48, "wr2 H@10");
        do_write(1'b1, 15, 8'h48, "wr2 H@15");
        scan(1'b1, 0, 41, 3, 3, "d2 row0");
        scan(1'b1, 0, 41, 19, 19, "d2 row1");
        scan(1'b1, 30, 41, 16, 33, "d2 cell9");

        // clr beats a simultaneous write; a second clr mid-sweep must not extend it
        @(negedge clk);
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 6'd5; wr_char = 8'h41;
        #1;
        chk("clr blocks wr_ready", wr_ready, 0);
        @(negedge clk);
        clr = 1'b0; wr_valid = 1'b0;
        wait_ready(1'b1, n1, n2);
        chk("clr sweep len", n1, 64);
        for (int i = 0; i < 64; i++) bufm[i] = 8'h00;
        for (int r = 0; r < 4; r++) scan(1'b0, 60, 323, 38 + 32 * r, 38 + 32 * r, "cleared");

        // Asynchronous reset part-way through a sweep
        do_write(1'b0, 63, 8'h48, "wr H@63 again");
        x = 10'd304; y = 10'd132;
        repeat (3) @(negedge clk);
        chk("H pixel on", text_on, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid-sweep wr_ready", wr_ready, 0);
        chk("cell 63 not yet swept", text_on, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async rst text_on", text_on, 0);
        chk("async rst text_rgb", text_rgb, 32'h0FF);
        chk("async rst wr_ready", wr_ready, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        wait_ready(1'b0, n1, n2);
        chk("restart sweep len", n1, 64);
        chk("restart sweep len2", n2, 10);
        repeat (3) @(negedge clk);
        chk("H cleared by sweep", text_on, 0);
        scan(1'b0, 300, 321, 130, 134, "post reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
